psum_accum_buf: RTL
===================

Name: psum_accum_buf

Overview:
- Row-wide partial-sum accumulator and replay buffer, directly upstream of the softmax/normalisation row (sfp_row).
- Accepts col-lane psum vectors from the output FIFO over cfg_tiles K-tile passes and accumulates them per row into a cfg_rows-deep buffer.
- Then drives sfp_row's sfp_in/acc/div/fifo_ext_rd, replaying each row twice: once for the abs-sum accumulate phase, once for the divide phase.

Parameters:
- col, 8, lanes per vector
- bw, 8, activation/weight width (reference only)
- bw_psum, 2*bw+4 (20), signed psum lane width
- depth, 16, buffer rows
- aw, 4, log2(depth)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; latches cfg and begins a job
- cfg_rows  in  aw+1  rows per job (1..depth)
- cfg_tiles  in  4  K-tile passes per job (1..15)
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts input
- in_data  in  col*bw_psum  signed psum lanes, lane0 in LSBs
- peer_ready  in  1  other core's sums written; DIV may begin
- sfp_data  out  col*bw_psum  to sfp_row sfp_in
- acc  out  1  to sfp_row acc
- div  out  1  to sfp_row div
- fifo_ext_rd  out  1  to sfp_row fifo_ext_rd
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async): state=IDLE; in_ready, acc, div, fifo_ext_rd, busy, done = 0; sfp_data = 0; all pointers/counters = 0. Buffer RAM is not reset and is don't-care.
- States: IDLE, ACCUM, EMIT_ACC, SYNC, EMIT_DIV, FIN.
- IDLE:
  - start with cfg_rows in 1..depth and cfg_tiles != 0: latch cfg, go to ACCUM.
  - Otherwise start is ignored.
  - cfg_rows > depth is treated as invalid and ignored.
- start while busy is ignored.
- ACCUM:
  - in_ready = 1; a beat is in_valid & in_ready.
  - Each beat updates buf[wptr] per lane.
  - Tile 0: buf[wptr] = in_data (overwrite).
  - Later tiles: buf[wptr] = sat(buf[wptr] + in_data).
  - Add is signed bw_psum+1 bits, saturating to [-2^(bw_psum-1), 2^(bw_psum-1)-1], lanes independent.
  - wptr wraps from cfg_rows-1 to 0 and tile_cnt increments on wrap.
  - The wrap of the final tile moves to EMIT_ACC; in_ready drops in the cycle after that last beat.
- EMIT_ACC:
  - For r = 0..cfg_rows-1, one row per cycle, no stalls: sfp_data = buf[r], acc = 1.
  - sfp_data, acc, div and fifo_ext_rd are registered together and always cycle-aligned.
  - First acc asserts the cycle after entering the state.
- SYNC:
  - All strobes 0; sfp_data holds its last value.
  - Minimum 2 cycles, which covers sfp_row's sum_q -> fifo_wr latency.
  - Exits when the 2 cycles have elapsed and peer_ready = 1. peer_ready already high gives exactly a 2-cycle gap.
- EMIT_DIV:
  - For r = 0..cfg_rows-1, one per cycle: sfp_data = buf[r], div = 1, fifo_ext_rd = 1.
- FIN: done = 1 for one cycle, then IDLE.
- busy = 1 in every state except IDLE.
- Input vectors arriving outside ACCUM are not accepted (in_ready = 0).
- Reset mid-job: immediate return to IDLE; outputs at reset values. The next job's tile 0 overwrite makes stale buffer contents harmless.
- Throughput: total job cycles = cfg_rows*cfg_tiles input beats + 2*cfg_rows + SYNC + 1 (FIN) + state-entry overhead.

Decomposition:
- Shared package:
  - bw_psum and col defaults
  - state encoding constants (IDLE..FIN)
  - PSUM_MAX / PSUM_MIN saturation constants
- One sub-module, psum_sat_add: per-lane signed saturating adder of width bw_psum, instantiated col times.
- Buffer is an inferred register array in the top module.

Test Plan:
- Single tile: cfg_rows=4, cfg_tiles=1, row r lanes = r*10+lane.
  - acc high exactly 4 consecutive cycles, sfp_data rows 0..3 in order.
  - 2-cycle gap.
  - div and fifo_ext_rd high 4 cycles with identical data.
  - done one cycle later.
- Multi-tile: cfg_rows=2, cfg_tiles=3, every beat lanes = -5 → both rows replayed with all lanes = -15.
- Saturation: cfg_tiles=2, lane0 = 300000 twice → 524287; lane1 = -300000 twice → -524288; other lanes unaffected.
- Backpressure and sync:
  - in_valid toggles 1/0 across a cfg_rows=16 job: accumulates correctly with wptr wrap 15→0.
  - peer_ready held low 10 cycles: div waits, starts one cycle after peer_ready rises, with no acc/div overlap.
- Reset mid-EMIT_ACC (after 2 of 4 rows): acc, busy and sfp_data go 0 asynchronously. A new job with cfg_tiles=1 replays only the new data.
- Config errors: start with cfg_rows=0, cfg_rows=17 or cfg_tiles=0 → busy stays 0. A start pulse during ACCUM does not disturb the job in progress.

Source files
------------

// File: rtl/psum_accum_buf_pkg.sv
// Shared widths, state encoding and saturation limits for the psum
// accumulate-and-replay buffer that feeds sfp_row.
package psum_accum_buf_pkg;

    localparam int COL     = 8;
    localparam int BW      = 8;
    localparam int BW_PSUM = 2 * BW + 4;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;

    localparam logic signed [BW_PSUM-1:0] PSUM_MAX = {1'b0, {(BW_PSUM-1){1'b1}}};
    localparam logic signed [BW_PSUM-1:0] PSUM_MIN = {1'b1, {(BW_PSUM-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_EMIT_ACC = 3'd2,
        ST_SYNC     = 3'd3,
        ST_EMIT_DIV = 3'd4,
        ST_FIN      = 3'd5
    } state_e;

    typedef logic [COL*BW_PSUM-1:0] vec_t;

    // A job is only started for 1..DEPTH rows and a non-zero tile count.
    function automatic logic cfg_ok(input logic [AW:0] rows, input logic [3:0] tiles);
        return (rows != 5'd0) && (rows <= 5'(DEPTH)) && (tiles != 4'd0);
    endfunction

endpackage

// File: rtl/psum_accum_buf_if.sv
// Input psum stream from the output FIFO plus the replay bus towards sfp_row.
interface psum_accum_buf_if;
    import psum_accum_buf_pkg::*;

    logic in_valid;
    logic in_ready;
    vec_t in_data;
    vec_t sfp_data;
    logic acc;
    logic div;
    logic fifo_ext_rd;

    modport master (
        output in_valid, in_data,
        input  in_ready, sfp_data, acc, div, fifo_ext_rd
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, sfp_data, acc, div, fifo_ext_rd
    );

endinterface

// File: rtl/psum_accum_buf_sat_add.sv
// One lane of signed saturating addition at psum width.
module psum_sat_add
    import psum_accum_buf_pkg::*;
(
    input  logic signed [BW_PSUM-1:0] a,
    input  logic signed [BW_PSUM-1:0] b,
    output logic signed [BW_PSUM-1:0] sum
);

    logic [BW_PSUM:0] wide_s;

    // Add one bit wider; differing top two bits mean the result left the range.
    always_comb begin
        wide_s = {a[BW_PSUM-1], a} + {b[BW_PSUM-1], b};
        if (wide_s[BW_PSUM] != wide_s[BW_PSUM-1]) begin
            if (wide_s[BW_PSUM]) begin
                sum = PSUM_MIN;
            end else begin
                sum = PSUM_MAX;
            end
        end else begin
            sum = wide_s[BW_PSUM-1:0];
        end
    end

endmodule

// File: rtl/psum_accum_buf.sv
// Row-wide psum accumulator: sums cfg_tiles passes of cfg_rows vectors into a
// local buffer, then replays each row to sfp_row twice (acc phase, div phase)
// with a peer-gated sync gap between the two replays.
module psum_accum_buf
    import psum_accum_buf_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     cfg_rows,
    input  logic [3:0]      cfg_tiles,
    input  logic            peer_ready,
    output logic            busy,
    output logic            done,
    psum_accum_buf_if.slave io
);

    state_e          state_r;
    logic [AW:0]     cfg_rows_r;
    logic [3:0]      cfg_tiles_r;
    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [3:0]      tile_cnt_r;
    logic            sync_done_r;
    logic            in_ready_r;
    logic            acc_r;
    logic            div_r;
    logic            fifo_ext_rd_r;
    logic            busy_r;
    logic            done_r;
    vec_t            sfp_data_r;

    vec_t            row_buf_r [DEPTH];

    vec_t            cur_row_s;
    vec_t            sum_row_s;
    logic            beat_s;
    logic [AW:0]     rows_m1_s;
    logic [AW-1:0]   last_row_s;
    logic [3:0]      last_tile_s;

    // Current buffer row, accepted-beat strobe and end-of-pass indices.
    always_comb begin
        cur_row_s   = row_buf_r[wptr_r];
        beat_s      = io.in_valid & in_ready_r;
        rows_m1_s   = cfg_rows_r - 5'd1;
        last_row_s  = rows_m1_s[AW-1:0];
        last_tile_s = cfg_tiles_r - 4'd1;
    end

    for (genvar l = 0; l < COL; l++) begin : g_lane
        psum_sat_add u_sat_add (
            .a   (cur_row_s[l*BW_PSUM +: BW_PSUM]),
            .b   (io.in_data[l*BW_PSUM +: BW_PSUM]),
            .sum (sum_row_s[l*BW_PSUM +: BW_PSUM])
        );
    end

    // Buffer write: tile 0 overwrites so stale rows never leak into a new job.
    always_ff @(posedge clk) begin
        if (beat_s) begin
            if (tile_cnt_r == 4'd0) begin
                row_buf_r[wptr_r] <= io.in_data;
            end else begin
                row_buf_r[wptr_r] <= sum_row_s;
            end
        end
    end

    // Job sequencer; every strobe and the replay data are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cfg_rows_r    <= 5'd0;
            cfg_tiles_r   <= 4'd0;
            wptr_r        <= 4'd0;
            rptr_r        <= 4'd0;
            tile_cnt_r    <= 4'd0;
            sync_done_r   <= 1'b0;
            in_ready_r    <= 1'b0;
            acc_r         <= 1'b0;
            div_r         <= 1'b0;
            fifo_ext_rd_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            sfp_data_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && cfg_ok(cfg_rows, cfg_tiles)) begin
                        cfg_rows_r  <= cfg_rows;
                        cfg_tiles_r <= cfg_tiles;
                        wptr_r      <= 4'd0;
                        rptr_r      <= 4'd0;
                        tile_cnt_r  <= 4'd0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat_s) begin
                        if (wptr_r == last_row_s) begin
                            wptr_r     <= 4'd0;
                            tile_cnt_r <= tile_cnt_r + 4'd1;
                            if (tile_cnt_r == last_tile_s) begin
                                in_ready_r <= 1'b0;
                                rptr_r     <= 4'd0;
                                state_r    <= ST_EMIT_ACC;
                            end
                        end else begin
                            wptr_r <= wptr_r + 4'd1;
                        end
                    end
                end
                ST_EMIT_ACC: begin
                    acc_r      <= 1'b1;
                    sfp_data_r <= row_buf_r[rptr_r];
                    if (rptr_r == last_row_s) begin
                        rptr_r      <= 4'd0;
                        sync_done_r <= 1'b0;
                        state_r     <= ST_SYNC;
                    end else begin
                        rptr_r <= rptr_r + 4'd1;
                    end
                end
                ST_SYNC: begin
                    // Two idle cycles minimum, then wait for the peer core.
                    acc_r <= 1'b0;
                    if (sync_done_r && peer_ready) begin
                        state_r <= ST_EMIT_DIV;
                    end else begin
                        sync_done_r <= 1'b1;
                    end
                end
                ST_EMIT_DIV: begin
                    div_r         <= 1'b1;
                    fifo_ext_rd_r <= 1'b1;
                    sfp_data_r    <= row_buf_r[rptr_r];
                    if (rptr_r == last_row_s) begin
                        rptr_r  <= 4'd0;
                        state_r <= ST_FIN;
                    end else begin
                        rptr_r <= rptr_r + 4'd1;
                    end
                end
                ST_FIN: begin
                    div_r         <= 1'b0;
                    fifo_ext_rd_r <= 1'b0;
                    done_r        <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    in_ready_r    <= 1'b0;
                    acc_r         <= 1'b0;
                    div_r         <= 1'b0;
                    fifo_ext_rd_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.in_ready    = in_ready_r;
    assign io.sfp_data    = sfp_data_r;
    assign io.acc         = acc_r;
    assign io.div         = div_r;
    assign io.fifo_ext_rd = fifo_ext_rd_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule
